// File: rtl/kfps2kb_pkg.sv
// Shared types and constants for the PS/2 keyboard keycode buffer.
package kfps2kb_pkg;

  typedef logic [7:0] keycode_t;

  localparam keycode_t KC_ERROR = 8'hFF;
  localparam keycode_t KC_NONE  = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT
  } up_state_t;

endpackage

// File: rtl/kfps2kb_fifo_mem.sv
// Dual-port register array: synchronous write, asynchronous read, data not reset.
module kfps2kb_fifo_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kfps2kb_keycode_buffer.sv
// Keycode FIFO between the PS/2 controller and the XT port A / IRQ1 interface.
// Optional KFPS2KB_OVERFLOW_MARKER_EN: first dropped code overwrites the newest entry with 8'hFF.
//
// state | meaning
// IDLE  | waiting for kb_irq, captures code on the sampling edge
// ACK   | clear_keycode pulse is high for this cycle
// WAIT  | holding off until upstream drops kb_irq
module kfps2kb_keycode_buffer
  import kfps2kb_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] IRQ_GAP    = 16'd8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                kb_irq,
  input  keycode_t            kb_keycode,
  output logic                clear_keycode,
  input  logic                cpu_ack,
  input  logic                cpu_clear,
  output logic                irq_out,
  output keycode_t            keycode_out,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow
);

  localparam int unsigned DEPTH_I = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = DEPTH_I[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  up_state_t             state_q;
  logic                  clear_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [15:0]           gap_q, gap_d;
  logic                  irq_q, irq_d;
  logic                  ovf_q, ovf_d;

  logic                  push_req, push_ok, pop, drop, full;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  keycode_t              mem_wdata, head;

  assign push_req = (state_q == IDLE) && kb_irq;
  assign full     = (count_q == FULL_CNT);
  assign pop      = cpu_ack && irq_q && !cpu_clear;
  assign push_ok  = push_req && !cpu_clear && (!full || pop);
  assign drop     = push_req && !cpu_clear && full && !pop;

  // Upstream handshake completes even when the code is dropped or flushed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      clear_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (kb_irq) begin
            clear_q <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          clear_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          clear_q <= 1'b0;
          if (!kb_irq) state_q <= IDLE;
        end
        default: begin
          clear_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    gap_d    = gap_q;
    ovf_d    = ovf_q;
    irq_d    = 1'b0;
    if (cpu_clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      gap_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (pop)               gap_d = IRQ_GAP;
      else if (gap_q != '0)  gap_d = gap_q - 16'd1;
      ovf_d = ovf_q || drop;
      // Re-assert on the edge where the gap counter reaches zero, so the low gap is IRQ_GAP clocks.
      irq_d = (count_q != '0) && (gap_d == '0) && !pop;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      gap_q    <= '0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef KFPS2KB_OVERFLOW_MARKER_EN
  logic marker_q, marker_d, marker_wr;

  assign marker_wr = drop && !marker_q;
  assign marker_d  = !cpu_clear && full && (marker_q || drop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) marker_q <= 1'b0;
    else       marker_q <= marker_d;
  end

  // When full, wr_ptr equals rd_ptr, so wr_ptr-1 is the newest entry.
  assign mem_we    = push_ok || marker_wr;
  assign mem_waddr = marker_wr ? (wr_ptr_q - PTR_ONE) : wr_ptr_q;
  assign mem_wdata = marker_wr ? KC_ERROR : kb_keycode;
`else
  assign mem_we    = push_ok;
  assign mem_waddr = wr_ptr_q;
  assign mem_wdata = kb_keycode;
`endif

  kfps2kb_fifo_mem #(
    .AW (DEPTH_LOG2),
    .DW (8)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign clear_keycode = clear_q;
  assign irq_out       = irq_q;
  assign count         = count_q;
  assign overflow      = ovf_q;
  assign keycode_out   = ((count_q == '0) || cpu_clear) ? KC_NONE : head;

endmodule

// File: tb/tb_kfps2kb_keycode_buffer.sv
// Directed self-checking bench for kfps2kb_keycode_buffer.
module tb_kfps2kb_keycode_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic       kb_irq;
  logic [7:0] kb_keycode;
  logic       clear_keycode;
  logic       cpu_ack;
  logic       cpu_clear;
  logic       irq_out;
  logic [7:0] keycode_out;
  logic [4:0] count;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  kfps2kb_keycode_buffer #(
    .DEPTH_LOG2 (4),
    .IRQ_GAP    (16'd8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .kb_irq        (kb_irq),
    .kb_keycode    (kb_keycode),
    .clear_keycode (clear_keycode),
    .cpu_ack       (cpu_ack),
    .cpu_clear     (cpu_clear),
    .irq_out       (irq_out),
    .keycode_out   (keycode_out),
    .count         (count),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All helpers are entered and left just after a falling edge.
  task automatic push_code(input logic [7:0] k);
    logic seen;
    seen = 1'b0;
    kb_irq = 1'b1;
    kb_keycode = k;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (clear_keycode) begin
        seen = 1'b1;
        break;
      end
    end
    check("push_handshake", {31'd0, seen}, 32'd1);
    kb_irq = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic ack();
    cpu_ack = 1'b1;
    @(negedge clock);
    cpu_ack = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (irq_out) break;
      @(negedge clock);
    end
    check(tag, {31'd0, irq_out}, 32'd1);
  endtask

  task automatic pulse_clear();
    cpu_clear = 1'b1;
    @(negedge clock);
    cpu_clear = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] burst [0:2];
    logic [7:0] exp_kc;
    int low;

    reset = 1'b1;
    kb_irq = 1'b0;
    kb_keycode = 8'h00;
    cpu_ack = 1'b0;
    cpu_clear = 1'b0;
    @(negedge clock);
    check("rst_clear", {31'd0, clear_keycode}, 32'd0);
    check("rst_irq", {31'd0, irq_out}, 32'd0);
    check("rst_kc", {24'd0, keycode_out}, 32'h00);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single code
    kb_irq = 1'b1;
    kb_keycode = 8'h1E;
    @(negedge clock);
    check("single_clear_hi", {31'd0, clear_keycode}, 32'd1);
    check("single_count", {27'd0, count}, 32'd1);
    check("single_irq_late", {31'd0, irq_out}, 32'd0);
    kb_irq = 1'b0;
    @(negedge clock);
    check("single_clear_lo", {31'd0, clear_keycode}, 32'd0);
    check("single_irq", {31'd0, irq_out}, 32'd1);
    check("single_kc", {24'd0, keycode_out}, 32'h1E);
    @(negedge clock);
    ack();
    check("single_pop_count", {27'd0, count}, 32'd0);
    check("single_pop_irq", {31'd0, irq_out}, 32'd0);
    check("single_pop_kc", {24'd0, keycode_out}, 32'h00);
    repeat (10) @(negedge clock);

    // Burst with IRQ gap
    burst[0] = 8'hE0;
    burst[1] = 8'h48;
    burst[2] = 8'hC8;
    for (int i = 0; i < 3; i++) push_code(burst[i]);
    check("burst_count", {27'd0, count}, 32'd3);
    check("burst_irq0", {31'd0, irq_out}, 32'd1);
    check("burst_kc0", {24'd0, keycode_out}, {24'd0, burst[0]});
    for (int i = 1; i < 3; i++) begin
      ack();
      low = 0;
      for (int j = 0; j < 30; j++) begin
        if (irq_out) break;
        low++;
        @(negedge clock);
      end
      check("burst_gap", low, 32'd8);
      check("burst_kc", {24'd0, keycode_out}, {24'd0, burst[i]});
    end
    ack();
    check("burst_end_count", {27'd0, count}, 32'd0);
    check("burst_end_irq", {31'd0, irq_out}, 32'd0);
    repeat (10) @(negedge clock);

    // Overflow: 17 codes into 16 entries
    for (int i = 1; i <= 17; i++) push_code(8'(i));
    check("ovf_count", {27'd0, count}, 32'd16);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      exp_kc = 8'(i);
`ifdef KFPS2KB_OVERFLOW_MARKER_EN
      if (i == 16) exp_kc = 8'hFF;
`endif
      wait_irq("ovf_drain_irq");
      check("ovf_drain_kc", {24'd0, keycode_out}, {24'd0, exp_kc});
      ack();
    end
    check("ovf_drained", {27'd0, count}, 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    pulse_clear();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Simultaneous push and pop while full
    for (int i = 0; i < 16; i++) push_code(8'(8'h21 + i));
    check("sim_full", {27'd0, count}, 32'd16);
    wait_irq("sim_irq");
    kb_irq = 1'b1;
    kb_keycode = 8'h31;
    cpu_ack = 1'b1;
    @(negedge clock);
    cpu_ack = 1'b0;
    kb_irq = 1'b0;
    check("sim_clear", {31'd0, clear_keycode}, 32'd1);
    check("sim_count", {27'd0, count}, 32'd16);
    check("sim_ovf", {31'd0, overflow}, 32'd0);
    check("sim_head", {24'd0, keycode_out}, 32'h22);
    @(negedge clock);
    @(negedge clock);
    pulse_clear();

    // Flush while pushing
    for (int i = 0; i < 5; i++) push_code(8'(8'h41 + i));
    check("flush_pre_count", {27'd0, count}, 32'd5);
    cpu_clear = 1'b1;
    kb_irq = 1'b1;
    kb_keycode = 8'h2A;
    @(negedge clock);
    check("flush_count", {27'd0, count}, 32'd0);
    check("flush_kc", {24'd0, keycode_out}, 32'h00);
    check("flush_irq", {31'd0, irq_out}, 32'd0);
    check("flush_clear", {31'd0, clear_keycode}, 32'd1);
    kb_irq = 1'b0;
    @(negedge clock);
    @(negedge clock);
    cpu_clear = 1'b0;
    @(negedge clock);
    check("flush_after_count", {27'd0, count}, 32'd0);
    check("flush_after_kc", {24'd0, keycode_out}, 32'h00);
    check("flush_after_irq", {31'd0, irq_out}, 32'd0);

    // Async reset during ACK
    kb_irq = 1'b1;
    kb_keycode = 8'h55;
    @(negedge clock);
    check("ar_in_ack", {31'd0, clear_keycode}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_clear", {31'd0, clear_keycode}, 32'd0);
    check("ar_count", {27'd0, count}, 32'd0);
    check("ar_irq", {31'd0, irq_out}, 32'd0);
    #1 reset = 1'b0;
    @(negedge clock);
    check("ar_recapture", {27'd0, count}, 32'd1);
    repeat (4) @(negedge clock);
    check("ar_once", {27'd0, count}, 32'd1);
    kb_irq = 1'b0;
    @(negedge clock);
    check("ar_kc", {24'd0, keycode_out}, 32'h55);
    check("ar_irq_up", {31'd0, irq_out}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
